pipe_reg: RTL and testbench
===========================

PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 Parameter WIDTH, default 32, data width in bits.
REQ-002 Parameter STAGES, default 1, number of chained skid stages; legal range 1..8.
REQ-003 Parameter RESET_VAL, default 0, value loaded into all data registers on reset.
REQ-004 CLK  input  1  single clock; all state changes on the rising edge.
REQ-005 RST  input  1  reset, synchronous, active-low.
REQ-006 Din  input  WIDTH  upstream data.
REQ-007 InValid  input  1  upstream offers Din this cycle.
REQ-008 InReady  output  1  block accepts Din this cycle.
REQ-009 Flush  input  1  discards all held entries.
REQ-010 Dout  output  WIDTH  head data.
REQ-011 OutValid  output  1  Dout holds a valid entry.
REQ-012 OutReady  input  1  downstream takes Dout this cycle.
REQ-013 Level  output  $clog2(2*STAGES+1)  total entries held across all stages.

Function
REQ-014 Transfer in occurs when InValid&InReady; transfer out occurs when OutValid&OutReady.
REQ-015 Each stage holds a main register and a skid register, with states EMPTY, ONE and FULL.
REQ-016 EMPTY: in -> ONE, main<=in.
REQ-017 ONE: in&out -> ONE, main<=in; in only -> FULL, skid<=in; out only -> EMPTY; neither -> ONE, hold.
REQ-018 FULL: out -> ONE, main<=skid; no out -> hold; in is impossible because stage InReady=0.
REQ-019 Stage InReady = (state!=FULL); stage OutValid = (state!=EMPTY); stage Dout = main; all three come straight from registers, with no combinational path from the stage's OutReady to its InReady.
REQ-020 Stages chain as stage k Dout/OutValid -> stage k+1 Din/InValid, and stage k+1 InReady -> stage k OutReady; the first stage faces upstream and the last stage drives Dout/OutValid.
REQ-021 Latency is STAGES cycles from an accepted input to OutValid at the output, when downstream is empty.
REQ-022 Throughput is one transfer per cycle when OutReady stays high; InReady never deasserts in that case.
REQ-023 Ordering is strict FIFO and no entry is dropped or duplicated, under any OutReady pattern.
REQ-024 Level increments on in-only, decrements on out-only, and holds on both or neither.
REQ-025 Flush=1 at an edge: all stages -> EMPTY, Level<=0, the input transfer of that cycle is discarded, and data registers keep their values.
REQ-026 Flush while EMPTY: no effect beyond holding EMPTY.
REQ-027 Priority: RST (low) > Flush > normal transfer.

Reset
REQ-028 RST low at an edge: every stage -> EMPTY, main and skid <= RESET_VAL, Level<=0.
REQ-029 Outputs after reset: Dout=RESET_VAL, OutValid=0, InReady=1, Level=0.
REQ-030 Reset mid-operation discards all entries in one edge, and the first input accepted after release appears STAGES cycles later.

Structure
REQ-031 A shared package pipe_pkg holds the stage-state encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) and the default WIDTH.
REQ-032 One sub-module, pipe_skid, implements a single stage; pipe_reg instantiates STAGES copies by generate and sums their occupancies into Level.
REQ-033 There are no latches, no asynchronous logic and one clock domain.

Verification
REQ-034 Reset: RST=0 for 1 edge -> Dout=0, OutValid=0, InReady=1, Level=0.
REQ-035 Single push (STAGES=1): Din=0x00000001 with InValid=1 for one cycle, OutReady=1 -> next cycle Dout=0x1, OutValid=1; the cycle after, OutValid=0, Level=0.
REQ-036 Backpressure: OutReady=0, push 0x00000007 then 0x40C06007 -> InReady=0, Level=2, Dout=0x7; then OutReady=1 -> Dout=0x7 taken, next Dout=0x40C06007, InReady=1.
REQ-037 Streaming: InValid=OutReady=1, Din=1..8 on consecutive cycles -> Dout=1..8 on consecutive cycles, InReady constantly 1.
REQ-038 Flush when FULL, with InValid=1 and Din=0x9 in the same cycle -> next cycle OutValid=0, Level=0, InReady=1, and 0x9 never appears.
REQ-039 STAGES=3: push 0x5 -> OutValid rises exactly 3 cycles later; a random OutReady pattern over 200 pushes -> output order equals input order.

Source files
------------

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared definitions for the chained skid-buffer pipeline:
//                per-stage state encoding, default data width and a helper
//                that converts a stage state into its entry count.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default data width used by both the stage and the top level.
    localparam int c_default_width = 32;

    // Stage occupancy states. The encoding equals the number of entries
    // held, which lets the top level sum occupancies directly.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

    // Number of entries a stage holds in a given state.
    function automatic logic [1:0] state_occupancy(input stage_state_t s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_skid
//  Description : One skid-buffer stage. A main register drives the output
//                and a skid register absorbs one extra entry, so the
//                upstream ready is purely registered (no combinational path
//                from downstream ready back to upstream ready).
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = c_default_width,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
    input  logic             i_clk,
    input  logic             i_rst_n,   // synchronous, active-low
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [1:0]       o_occ
);

    stage_state_t     r_state;
    stage_state_t     w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;

    logic w_ready;
    logic w_valid;
    logic w_in_fire;
    logic w_out_fire;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    // Handshake qualifiers come only from the state register.
    assign w_ready    = (r_state != ST_FULL);
    assign w_valid    = (r_state != ST_EMPTY);
    assign w_in_fire  = i_valid & w_ready;
    assign w_out_fire = w_valid & i_ready;

    assign o_ready = w_ready;
    assign o_valid = w_valid;
    assign o_dout  = r_main;
    assign o_occ   = state_occupancy(r_state);

    // Next-state and register-load decode; flush empties the stage and
    // suppresses every load so the data registers keep their contents.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_state_nxt    = ST_ONE;
                    w_load_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_state_nxt = ST_FULL;
                    w_load_skid = 1'b1;
                end else if (w_out_fire) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // Upstream ready is low here, so only the output can move.
                if (w_out_fire) begin
                    w_state_nxt      = ST_ONE;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
        if (i_flush) begin
            w_state_nxt      = ST_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // Stage state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main and skid data registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_main <= RESET_VAL;
            r_skid <= RESET_VAL;
        end else begin
            if (w_load_main_in) begin
                r_main <= i_din;
            end else if (w_load_main_skid) begin
                r_main <= r_skid;
            end
            if (w_load_skid) begin
                r_skid <= i_din;
            end
        end
    end

endmodule : pipe_skid
`default_nettype wire

// File: rtl/pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_reg
//  Description : Chain of STAGES skid-buffer stages giving a fully registered
//                valid/ready pipeline with flush and an occupancy count.
//                STAGES is intended to lie in 1..8.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_reg
    import pipe_pkg::*;
#(
    parameter int               WIDTH     = c_default_width,
    parameter int               STAGES    = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
)(
    input  logic                              CLK,
    input  logic                              RST,      // synchronous, active-low
    input  logic [WIDTH-1:0]                  Din,
    input  logic                              InValid,
    output logic                              InReady,
    input  logic                              Flush,
    output logic [WIDTH-1:0]                  Dout,
    output logic                              OutValid,
    input  logic                              OutReady,
    output logic [$clog2(2*STAGES+1)-1:0]     Level
);

    localparam int c_level_w = $clog2(2*STAGES+1);

    // Inter-stage links: index k is the input side of stage k,
    // index STAGES is the pipeline output.
    logic [WIDTH-1:0] w_data  [0:STAGES];
    logic             w_valid [0:STAGES];
    logic             w_ready [0:STAGES];
    logic [1:0]       w_occ   [0:STAGES-1];
    logic [c_level_w-1:0] w_level;

    assign w_data[0]       = Din;
    assign w_valid[0]      = InValid;
    assign InReady         = w_ready[0];
    assign Dout            = w_data[STAGES];
    assign OutValid        = w_valid[STAGES];
    assign w_ready[STAGES] = OutReady;
    assign Level           = w_level;

    genvar g;
    generate
        for (g = 0; g < STAGES; g++) begin : g_stage
            pipe_skid #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .i_clk   (CLK),
                .i_rst_n (RST),
                .i_flush (Flush),
                .i_din   (w_data[g]),
                .i_valid (w_valid[g]),
                .o_ready (w_ready[g]),
                .o_dout  (w_data[g+1]),
                .o_valid (w_valid[g+1]),
                .i_ready (w_ready[g+1]),
                .o_occ   (w_occ[g])
            );
        end
    endgenerate

    // Total entries held: sum of per-stage occupancies, all registered.
    always_comb begin
        w_level = '0;
        for (int k = 0; k < STAGES; k++) begin
            w_level = w_level + c_level_w'(w_occ[k]);
        end
    end

endmodule : pipe_reg
`default_nettype wire

// File: tb/tb_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_reg
//  Description : Self-checking bench for pipe_reg. A single-stage instance
//                is driven from a table of vectors; a three-stage instance
//                gets latency, streaming, reset and randomized traffic
//                checked against a FIFO queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_reg;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Single-stage instance
    logic [31:0] din1, dout1;
    logic        iv1, ir1, fl1, ov1, or1;
    logic [1:0]  lvl1;

    // Three-stage instance
    logic [31:0] din3, dout3;
    logic        iv3, ir3, fl3, ov3, or3;
    logic [2:0]  lvl3;

    localparam logic [31:0] c_rv3 = 32'hA5A5_0000;

    pipe_reg #(.WIDTH(32), .STAGES(1), .RESET_VAL(32'h0)) u_dut1 (
        .CLK(clk), .RST(rst_n), .Din(din1), .InValid(iv1), .InReady(ir1),
        .Flush(fl1), .Dout(dout1), .OutValid(ov1), .OutReady(or1), .Level(lvl1)
    );

    pipe_reg #(.WIDTH(32), .STAGES(3), .RESET_VAL(c_rv3)) u_dut3 (
        .CLK(clk), .RST(rst_n), .Din(din3), .InValid(iv3), .InReady(ir3),
        .Flush(fl3), .Dout(dout3), .OutValid(ov3), .OutReady(or3), .Level(lvl3)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        iv;
        logic [31:0] din;
        logic        ordy;
        logic        fl;
        logic        exp_ov;
        logic [31:0] exp_dout;
        logic        exp_ir;
        logic [1:0]  exp_lvl;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic iv, input logic [31:0] din, input logic ordy,
                        input logic fl, input logic eov, input logic [31:0] edout,
                        input logic eir, input logic [1:0] elvl);
        vec_t v;
        v.iv = iv; v.din = din; v.ordy = ordy; v.fl = fl;
        v.exp_ov = eov; v.exp_dout = edout; v.exp_ir = eir; v.exp_lvl = elvl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and land just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one word into the 3-stage instance and watch it emerge.
    task automatic lat3(input logic [31:0] v, input string tag);
        iv3 = 1'b1; din3 = v; or3 = 1'b1;
        step();
        chk($sformatf("%s ov_after_1", tag), 32'(ov3), 32'd0);
        iv3 = 1'b0;
        step();
        chk($sformatf("%s ov_after_2", tag), 32'(ov3), 32'd0);
        step();
        chk($sformatf("%s ov_after_3", tag), 32'(ov3), 32'd1);
        chk($sformatf("%s dout_after_3", tag), dout3, v);
        step();
        chk($sformatf("%s ov_drained", tag), 32'(ov3), 32'd0);
        chk($sformatf("%s lvl_drained", tag), 32'(lvl3), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] q[$];
        int pushed;
        int cyc;

        rst_n = 1'b0;
        din1 = '0; iv1 = 1'b0; fl1 = 1'b0; or1 = 1'b1;
        din3 = '0; iv3 = 1'b0; fl3 = 1'b0; or3 = 1'b1;

        // ---------------- reset ----------------
        step();
        chk("rst dout1", dout1, 32'h0);
        chk("rst ov1", 32'(ov1), 32'd0);
        chk("rst ir1", 32'(ir1), 32'd1);
        chk("rst lvl1", 32'(lvl1), 32'd0);
        chk("rst dout3", dout3, c_rv3);
        chk("rst ov3", 32'(ov3), 32'd0);
        chk("rst ir3", 32'(ir3), 32'd1);
        chk("rst lvl3", 32'(lvl3), 32'd0);
        rst_n = 1'b1;

        // ---------------- single-stage vector table ----------------
        //   iv  din            ordy fl  | ov dout          ir lvl
        addv(1, 32'h1,          1, 0,     1, 32'h1,          1, 2'd1);
        addv(0, 32'h0,          1, 0,     0, 32'h1,          1, 2'd0);
        addv(1, 32'h7,          0, 0,     1, 32'h7,          1, 2'd1);
        addv(1, 32'h40C06007,   0, 0,     1, 32'h7,          0, 2'd2);
        addv(1, 32'hDEAD,       1, 0,     1, 32'h40C06007,   1, 2'd1);
        addv(0, 32'h0,          1, 0,     0, 32'h40C06007,   1, 2'd0);
        for (int k = 1; k <= 8; k++)
            addv(1, 32'(k),     1, 0,     1, 32'(k),         1, 2'd1);
        addv(0, 32'h0,          1, 0,     0, 32'h8,          1, 2'd0);
        addv(1, 32'hA,          0, 0,     1, 32'hA,          1, 2'd1);
        addv(1, 32'hB,          0, 0,     1, 32'hA,          0, 2'd2);
        addv(0, 32'h0,          0, 0,     1, 32'hA,          0, 2'd2);
        addv(1, 32'h9,          0, 1,     0, 32'hA,          1, 2'd0);
        addv(0, 32'h0,          1, 0,     0, 32'hA,          1, 2'd0);
        addv(1, 32'hC,          0, 0,     1, 32'hC,          1, 2'd1);
        addv(1, 32'h9,          1, 1,     0, 32'hC,          1, 2'd0);
        addv(0, 32'h0,          0, 1,     0, 32'hC,          1, 2'd0);
        addv(1, 32'hD,          1, 0,     1, 32'hD,          1, 2'd1);
        addv(0, 32'h0,          1, 0,     0, 32'hD,          1, 2'd0);

        foreach (vecs[i]) begin
            iv1 = vecs[i].iv; din1 = vecs[i].din; or1 = vecs[i].ordy; fl1 = vecs[i].fl;
            step();
            chk($sformatf("row%0d ov", i),   32'(ov1),  32'(vecs[i].exp_ov));
            chk($sformatf("row%0d dout", i), dout1,     vecs[i].exp_dout);
            chk($sformatf("row%0d ir", i),   32'(ir1),  32'(vecs[i].exp_ir));
            chk($sformatf("row%0d lvl", i),  32'(lvl1), 32'(vecs[i].exp_lvl));
        end
        iv1 = 1'b0; fl1 = 1'b0; or1 = 1'b1;

        // ---------------- three-stage latency ----------------
        lat3(32'h5, "lat3");

        // ---------------- three-stage streaming ----------------
        for (int i = 0; i < 12; i++) begin
            iv3 = 1'b1; din3 = 32'(100 + i); or3 = 1'b1;
            chk($sformatf("stream3 ir c%0d", i), 32'(ir3), 32'd1);
            step();
            if (i >= 2) begin
                chk($sformatf("stream3 ov c%0d", i), 32'(ov3), 32'd1);
                chk($sformatf("stream3 dout c%0d", i), dout3, 32'(100 + i - 2));
            end
        end
        iv3 = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk("stream3 drained lvl", 32'(lvl3), 32'd0);

        // ---------------- reset mid-operation ----------------
        or3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iv3 = 1'b1; din3 = 32'(200 + i);
            step();
        end
        chk("midrst lvl before", 32'(lvl3), 32'd4);
        rst_n = 1'b0; iv3 = 1'b1; din3 = 32'h99;
        step();
        chk("midrst ov3", 32'(ov3), 32'd0);
        chk("midrst lvl3", 32'(lvl3), 32'd0);
        chk("midrst ir3", 32'(ir3), 32'd1);
        chk("midrst dout3", dout3, c_rv3);
        rst_n = 1'b1; iv3 = 1'b0; or3 = 1'b1;
        lat3(32'h77, "postrst");

        // ---------------- randomized traffic vs FIFO model ----------------
        pushed = 0;
        cyc    = 0;
        while ((pushed < 200 || q.size() != 0) && cyc < 5000) begin
            iv3  = (pushed < 200) && ($urandom_range(0, 3) != 0);
            din3 = $urandom;
            or3  = ($urandom_range(0, 9) < (((cyc % 64) < 32) ? 2 : 8));
            fl3  = 1'b0;
            if (ov3 && or3) begin
                if (q.size() == 0) begin
                    chk("rand spurious output", dout3, 32'hFFFF_FFFF ^ dout3);
                end else begin
                    chk($sformatf("rand order c%0d", cyc), dout3, q[0]);
                    void'(q.pop_front());
                end
            end
            if (iv3 && ir3) begin
                q.push_back(din3);
                pushed++;
            end
            step();
            cyc++;
            chk($sformatf("rand level c%0d", cyc), 32'(lvl3), 32'(q.size()));
        end
        iv3 = 1'b0;
        chk("rand all pushed", 32'(pushed), 32'd200);
        chk("rand model drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_reg
`default_nettype wire
